// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter.
// Holds the FSM state encoding, default widths and the branch function codes
// understood by the downstream ALU_32BIT.
package alu_arb_pkg;

    localparam int ARB_WIDTH  = 32;
    localparam int ARB_FUNC_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Branch-compare function codes; all other codes are plain ALU operations.
    localparam logic [ARB_FUNC_W-1:0] FUNC_BLTZ = 6'b111000;
    localparam logic [ARB_FUNC_W-1:0] FUNC_BGEZ = 6'b111001;
    localparam logic [ARB_FUNC_W-1:0] FUNC_BEQ  = 6'b111100;
    localparam logic [ARB_FUNC_W-1:0] FUNC_BNE  = 6'b111101;
    localparam logic [ARB_FUNC_W-1:0] FUNC_BLEZ = 6'b111110;
    localparam logic [ARB_FUNC_W-1:0] FUNC_BGTZ = 6'b111111;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester-side bundle of the ALU sharing arbiter: request and response
// handshakes for port 0 (execute stage) and port 1 (branch-compare unit).
//   master : requester side (drives Valid/Func/A/B/RspReady)
//   slave  : arbiter side   (drives Ready/RspValid/O/Branch)
interface alu_share_arbiter_if
    import alu_arb_pkg::*;
#(
    parameter int WIDTH  = ARB_WIDTH,
    parameter int FUNC_W = ARB_FUNC_W
);
    logic              R0_Valid_in,     R1_Valid_in;
    logic              R0_Ready_out,    R1_Ready_out;
    logic [FUNC_W-1:0] R0_Func_in,      R1_Func_in;
    logic [WIDTH-1:0]  R0_A_in,         R1_A_in;
    logic [WIDTH-1:0]  R0_B_in,         R1_B_in;
    logic              R0_RspValid_out, R1_RspValid_out;
    logic              R0_RspReady_in,  R1_RspReady_in;
    logic [WIDTH-1:0]  R0_O_out,        R1_O_out;
    logic              R0_Branch_out,   R1_Branch_out;

    modport master (
        output R0_Valid_in, R1_Valid_in, R0_Func_in, R1_Func_in,
               R0_A_in, R1_A_in, R0_B_in, R1_B_in,
               R0_RspReady_in, R1_RspReady_in,
        input  R0_Ready_out, R1_Ready_out, R0_RspValid_out, R1_RspValid_out,
               R0_O_out, R1_O_out, R0_Branch_out, R1_Branch_out
    );

    modport slave (
        input  R0_Valid_in, R1_Valid_in, R0_Func_in, R1_Func_in,
               R0_A_in, R1_A_in, R0_B_in, R1_B_in,
               R0_RspReady_in, R1_RspReady_in,
        output R0_Ready_out, R1_Ready_out, R0_RspValid_out, R1_RspValid_out,
               R0_O_out, R1_O_out, R0_Branch_out, R1_Branch_out
    );

endinterface

// File: rtl/alu_share_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector
//   advance    : a grant is being taken this cycle; rotate the pointer
//   grant[1:0] : one-hot grant (zero when nothing requests)
//   ptr        : pointer register, 0 favours req[0], 1 favours req[1]
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       ptr
);

    always_comb begin
        // NOTE: default first so every path assigns grant and no latch is inferred.
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // After a grant the pointer favours the port that lost (or did not ask).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            // NOTE: non-blocking assignment for all clocked state.
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU_32BIT between the execute stage (port 0) and the
// branch-compare unit (port 1).  One operation at a time: IDLE grants a port
// and captures its operands, EXEC presents them to the ALU and captures the
// result, RESP holds the result until the owner consumes it.
//   Clk_in, Reset_n_in      : clock, asynchronous active-low reset
//   bus (slave)             : request/response handshakes of both ports
//   Alu_Func_out/A/B_out    : operand registers driven to the ALU
//   Alu_O_in, Alu_Branch_in : combinational ALU result
//   Busy_out                : state is not IDLE
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH  = ARB_WIDTH,
    parameter int FUNC_W = ARB_FUNC_W
) (
    input  logic               Clk_in,
    input  logic               Reset_n_in,
    alu_share_arbiter_if.slave bus,
    output logic [FUNC_W-1:0]  Alu_Func_out,
    output logic [WIDTH-1:0]   Alu_A_out,
    output logic [WIDTH-1:0]   Alu_B_out,
    input  logic [WIDTH-1:0]   Alu_O_in,
    input  logic               Alu_Branch_in,
    output logic               Busy_out
);

    state_t            state;
    logic              owner;        // 0: port 0 owns the ALU, 1: port 1
    logic [FUNC_W-1:0] func_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  o_q;
    logic              branch_q;
    logic [1:0]        rsp_valid_q;
    logic              busy_q;

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              advance;
    logic              owner_ready;
    logic              ptr_unused;   // grant already encodes the pointer's effect

    assign req         = {bus.R1_Valid_in, bus.R0_Valid_in};
    assign advance     = (state == ST_IDLE);
    assign owner_ready = owner ? bus.R1_RspReady_in : bus.R0_RspReady_in;

    rr_arbiter_2 u_rr (
        .clk     (Clk_in),
        .rst_n   (Reset_n_in),
        .req     (req),
        .advance (advance),
        .grant   (grant),
        .ptr     (ptr_unused)
    );

    // Ready is a pure function of state and requests; it is gated by reset so
    // no request is acknowledged while the block is held in reset.
    assign bus.R0_Ready_out = Reset_n_in && (state == ST_IDLE) && grant[0];
    assign bus.R1_Ready_out = Reset_n_in && (state == ST_IDLE) && grant[1];

    always_ff @(posedge Clk_in or negedge Reset_n_in) begin
        if (!Reset_n_in) begin
            // NOTE: every register, including data registers, is reset so the
            // ALU inputs and result outputs are defined zeros after reset.
            state       <= ST_IDLE;
            owner       <= 1'b0;
            func_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            o_q         <= '0;
            branch_q    <= 1'b0;
            rsp_valid_q <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        owner  <= grant[1];
                        func_q <= grant[1] ? bus.R1_Func_in : bus.R0_Func_in;
                        a_q    <= grant[1] ? bus.R1_A_in    : bus.R0_A_in;
                        b_q    <= grant[1] ? bus.R1_B_in    : bus.R0_B_in;
                        busy_q <= 1'b1;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    o_q         <= Alu_O_in;
                    branch_q    <= Alu_Branch_in;
                    rsp_valid_q <= owner ? 2'b10 : 2'b01;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (owner_ready) begin
                        rsp_valid_q <= 2'b00;
                        busy_q      <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 2'b00;
                    busy_q      <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand registers feed the ALU in every state so its inputs stay quiet.
    assign Alu_Func_out = func_q;
    assign Alu_A_out    = a_q;
    assign Alu_B_out    = b_q;

    // Both ports see the same result registers; only the owner gets RspValid.
    assign bus.R0_O_out        = o_q;
    assign bus.R1_O_out        = o_q;
    assign bus.R0_Branch_out   = branch_q;
    assign bus.R1_Branch_out   = branch_q;
    assign bus.R0_RspValid_out = rsp_valid_q[0];
    assign bus.R1_RspValid_out = rsp_valid_q[1];
    assign Busy_out            = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a stand-in ALU, a
// transaction-level arbitration model and a response scoreboard.
module tb_alu_share_arbiter;
    import alu_arb_pkg::*;

    localparam int W  = 32;
    localparam int FW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(W), .FUNC_W(FW)) bus ();

    logic [FW-1:0] alu_func;
    logic [W-1:0]  alu_a, alu_b, alu_o;
    logic          alu_branch, busy;

    alu_share_arbiter #(.WIDTH(W), .FUNC_W(FW)) dut (
        .Clk_in        (clk),
        .Reset_n_in    (rst_n),
        .bus           (bus),
        .Alu_Func_out  (alu_func),
        .Alu_A_out     (alu_a),
        .Alu_B_out     (alu_b),
        .Alu_O_in      (alu_o),
        .Alu_Branch_in (alu_branch),
        .Busy_out      (busy)
    );

    // Stand-in ALU: branch flag from the branch code rules, simple arithmetic result.
    function automatic logic [W:0] ref_alu(input logic [FW-1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic          br;
        logic [W-1:0]  o;
        br = 1'b0;
        case (f)
            FUNC_BLTZ: br = ($signed(a) <  0);
            FUNC_BGEZ: br = ($signed(a) >= 0);
            FUNC_BEQ:  br = (a == b);
            FUNC_BNE:  br = (a != b);
            FUNC_BLEZ: br = ($signed(a) <= 0);
            FUNC_BGTZ: br = ($signed(a) >  0);
            default:   br = 1'b0;
        endcase
        case (f)
            6'b100010: o = a - b;
            6'b100100: o = a & b;
            6'b100101: o = a | b;
            6'b100110: o = a ^ b;
            default:   o = a + b;
        endcase
        return {br, o};
    endfunction

    always_comb {alu_branch, alu_o} = ref_alu(alu_func, alu_a, alu_b);

    typedef struct {
        logic [FW-1:0] func;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
    } req_t;

    typedef struct {
        int            port;
        logic [FW-1:0] func;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  o;
        logic          br;
        int            gcyc;
    } exp_t;

    req_t pend0[$];
    req_t pend1[$];
    exp_t sb[$];
    int   got_port[$];
    logic got_br[$];
    logic [W-1:0] got_o[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_winner = 1;   // model: R0 favoured after reset
    logic rsp_rand = 1'b0;
    logic [W-1:0] last_o  = '0;
    logic         last_br = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive_inputs();
        bus.R0_Valid_in = (pend0.size() > 0);
        bus.R1_Valid_in = (pend1.size() > 0);
        if (pend0.size() > 0) begin
            bus.R0_Func_in = pend0[0].func; bus.R0_A_in = pend0[0].a; bus.R0_B_in = pend0[0].b;
        end else begin
            bus.R0_Func_in = FW'($urandom); bus.R0_A_in = $urandom; bus.R0_B_in = $urandom;
        end
        if (pend1.size() > 0) begin
            bus.R1_Func_in = pend1[0].func; bus.R1_A_in = pend1[0].a; bus.R1_B_in = pend1[0].b;
        end else begin
            bus.R1_Func_in = FW'($urandom); bus.R1_A_in = $urandom; bus.R1_B_in = $urandom;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {bus.R0_Ready_out, bus.R1_Ready_out, bus.R0_RspValid_out,
                              bus.R1_RspValid_out, busy, bus.R0_Branch_out, bus.R1_Branch_out}, 0);
        check({tag, "_o"},   {bus.R0_O_out, bus.R1_O_out}, 0);
        check({tag, "_alu"}, {alu_func, alu_a, alu_b}, 0);
    endtask

    // One clock: check arbitration at the negedge, update inputs just after posedge.
    task automatic step();
        logic       idle;
        logic [1:0] exp_rdy;
        int         w;
        req_t       r;
        logic [W:0] res;
        w = -1;
        @(negedge clk);
        if (rst_n) begin
            idle    = (sb.size() == 0);
            exp_rdy = 2'b00;
            check("busy", busy, !idle);
            if (idle) begin
                if (bus.R0_Valid_in && bus.R1_Valid_in) w = 1 - last_winner;
                else if (bus.R0_Valid_in)               w = 0;
                else if (bus.R1_Valid_in)               w = 1;
                if (w >= 0) exp_rdy[w] = 1'b1;
            end
            check("ready", {bus.R1_Ready_out, bus.R0_Ready_out}, exp_rdy);
            if (!idle && sb[0].gcyc == cyc - 1)
                check("alu_operands", {alu_func, alu_a, alu_b}, {sb[0].func, sb[0].a, sb[0].b});
            if (w >= 0) begin
                last_winner = w;
                r   = (w == 1) ? pend1[0] : pend0[0];
                res = ref_alu(r.func, r.a, r.b);
                sb.push_back('{port: w, func: r.func, a: r.a, b: r.b, o: res[W-1:0], br: res[W], gcyc: cyc});
            end
        end
        @(posedge clk);
        #1;
        if (w == 0) void'(pend0.pop_front());
        if (w == 1) void'(pend1.pop_front());
        if (rsp_rand) begin
            bus.R0_RspReady_in = ($urandom_range(0, 9) < 7);
            bus.R1_RspReady_in = ($urandom_range(0, 9) < 7);
        end
        drive_inputs();
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n;
        n = 0;
        while ((pend0.size() > 0 || pend1.size() > 0 || sb.size() > 0) && n < max_cycles) begin
            step();
            n++;
        end
        if (n >= max_cycles) check("drain_timeout", 1, 0);
        step();
    endtask

    task automatic clear_got();
        got_port.delete(); got_br.delete(); got_o.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pend0.delete(); pend1.delete();
        last_winner = 1;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard on each response handshake, checks hold otherwise.
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            sb.delete();
            last_o  = '0;
            last_br = 1'b0;
        end else if (sb.size() > 0 && cyc >= sb[0].gcyc + 2) begin
            check("rsp_valid", {bus.R1_RspValid_out, bus.R0_RspValid_out}, (sb[0].port == 1) ? 2'b10 : 2'b01);
            check("rsp_data", {bus.R1_O_out, bus.R0_O_out, bus.R1_Branch_out, bus.R0_Branch_out},
                  {sb[0].o, sb[0].o, sb[0].br, sb[0].br});
            if ((sb[0].port == 1) ? bus.R1_RspReady_in : bus.R0_RspReady_in) begin
                got_port.push_back(sb[0].port);
                got_br.push_back(bus.R0_Branch_out);
                got_o.push_back(bus.R0_O_out);
                last_o  = sb[0].o;
                last_br = sb[0].br;
                void'(sb.pop_front());
            end
        end else begin
            check("rsp_idle", {bus.R1_RspValid_out, bus.R0_RspValid_out}, 2'b00);
            check("rsp_hold", {bus.R1_O_out, bus.R0_O_out, bus.R1_Branch_out, bus.R0_Branch_out},
                  {last_o, last_o, last_br, last_br});
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs: everything must read zero.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus.R0_Valid_in = 1'(($urandom)); bus.R1_Valid_in = 1'($urandom);
            bus.R0_RspReady_in = 1'($urandom); bus.R1_RspReady_in = 1'($urandom);
            bus.R0_Func_in = FW'($urandom); bus.R1_Func_in = FW'($urandom);
            bus.R0_A_in = $urandom; bus.R0_B_in = $urandom; bus.R1_A_in = $urandom; bus.R1_B_in = $urandom;
            @(negedge clk);
            check_all_zero("reset");
        end
        @(posedge clk); #1;
        bus.R0_RspReady_in = 1'b1; bus.R1_RspReady_in = 1'b1;
        drive_inputs();
        rst_n = 1'b1;

        // Single R0 BEQ 5,5.
        clear_got();
        pend0.push_back('{FUNC_BEQ, 32'd5, 32'd5});
        drive_inputs();
        run_until_idle(20);
        check("beq_count", got_port.size(), 1);
        if (got_port.size() == 1) begin
            check("beq_port", got_port[0], 0);
            check("beq_branch", got_br[0], 1);
        end

        // Both valid from reset: R0 first, then R1; again R0 first.
        do_reset();
        clear_got();
        pend0.push_back('{FUNC_BNE, 32'd0, 32'd1});
        pend1.push_back('{FUNC_BGTZ, 32'd15, 32'd0});
        drive_inputs();
        run_until_idle(30);
        pend0.push_back('{6'b100000, 32'd1, 32'd2});
        pend1.push_back('{6'b100010, 32'd9, 32'd4});
        drive_inputs();
        run_until_idle(30);
        check("both_count", got_port.size(), 4);
        if (got_port.size() == 4) begin
            check("both_order", {got_port[0][1:0], got_port[1][1:0], got_port[2][1:0], got_port[3][1:0]}, 8'b00010001);
            check("both_branch", {got_br[0], got_br[1]}, 2'b11);
        end

        // Backpressure on R1 while R0 waits.
        clear_got();
        bus.R1_RspReady_in = 1'b0;
        pend1.push_back('{FUNC_BLTZ, 32'hFFFF_FFFF, 32'd0});
        drive_inputs();
        step();
        pend0.push_back('{6'b100101, 32'h00F0, 32'h0F00});
        drive_inputs();
        repeat (7) step();
        check("bp_busy", busy, 1);
        bus.R1_RspReady_in = 1'b1;
        run_until_idle(30);
        check("bp_count", got_port.size(), 2);
        if (got_port.size() == 2) begin
            check("bp_order", {got_port[0][1:0], got_port[1][1:0]}, 4'b0100);
            check("bp_result", {got_o[0], got_br[0]}, {32'hFFFF_FFFF, 1'b1});
        end

        // Reset in EXEC discards the operation.
        clear_got();
        pend0.push_back('{FUNC_BGEZ, 32'd0, 32'd7});
        drive_inputs();
        step();
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        pend0.delete(); pend1.delete();
        last_winner = 1;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) step();
        check("no_stale_rsp", got_port.size(), 0);
        pend1.push_back('{FUNC_BLEZ, 32'd0, 32'd3});
        drive_inputs();
        run_until_idle(20);
        check("blez_count", got_port.size(), 1);
        if (got_port.size() == 1) check("blez_result", {got_port[0][1:0], got_br[0]}, 3'b011);

        // Unknown function code passes through.
        clear_got();
        pend0.push_back('{6'b000000, 32'd3, 32'd4});
        drive_inputs();
        run_until_idle(20);
        check("unk_count", got_port.size(), 1);
        if (got_port.size() == 1) check("unk_result", {got_o[0], got_br[0]}, {32'd7, 1'b0});

        // Randomized traffic with random response backpressure.
        rsp_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [FW-1:0] f;
            logic [W-1:0]  a, b;
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       f = FW'($urandom);
                        1:       f = 6'b111000 | FW'($urandom_range(0, 7));
                        default: f = 6'b100000 | FW'($urandom_range(0, 7));
                    endcase
                    a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) - 32'd1 : $urandom;
                    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                    if (p == 0 && pend0.size() < 2) pend0.push_back('{f, a, b});
                    if (p == 1 && pend1.size() < 2) pend1.push_back('{f, a, b});
                end
            end
            drive_inputs();
            step();
        end
        rsp_rand = 1'b0;
        bus.R0_RspReady_in = 1'b1; bus.R1_RspReady_in = 1'b1;
        run_until_idle(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
